// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Moore control FSM for a multi-cycle MIPS-subset CPU built around a shared
// ALU and a single memory. Each instruction goes through FETCH and DECODE,
// then through an opcode-specific execute / memory / writeback path, and
// returns to FETCH.
//
// Parameters
//   MEM_LATENCY  cycles each memory access state is held (>= 1)
//   STATE_W      width of the o_state debug output
//
// Ports
//   i_clk, i_reset   clock and synchronous active-high reset
//   i_instruction    instruction register contents
//   i_stall          freeze FSM and latency counter; suppress write strobes
//   o_pcwrite        unconditional PC write
//   o_branch, o_bne  conditional PC write and condition invert
//   o_iord           memory address source (0 = PC, 1 = ALUOut)
//   o_memread        memory read
//   o_memwrite       memory write (single-cycle pulse)
//   o_irwrite        IR load
//   o_memtoreg       register write data (1 = MDR, 0 = ALUOut)
//   o_regdst         destination register (1 = rd, 0 = rt)
//   o_regwrite       register file write
//   o_jal            write PC to $31
//   o_alusrca        ALU A operand (0 = PC, 1 = regA)
//   o_alusrcb        ALU B operand (00 regB, 01 4, 10 ext(imm), 11 sext<<2)
//   o_extop          immediate extension (0 = sign, 1 = zero)
//   o_aluop          ALU operation (000 ADD, 001 SUB, 010 XOR, 011 SLT)
//   o_pcsource       PC source (00 ALU, 01 ALUOut, 10 jump, 11 regA)
//   o_illegal        pulse in DECODE for an unsupported encoding
//   o_state          current FSM state (debug)
// ---------------------------------------------------------------------------
module multicycle_controller #(
    parameter int MEM_LATENCY = 1,
    parameter int STATE_W     = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [31:0]        i_instruction,
    input  logic               i_stall,
    output logic               o_pcwrite,
    output logic               o_branch,
    output logic               o_bne,
    output logic               o_iord,
    output logic               o_memread,
    output logic               o_memwrite,
    output logic               o_irwrite,
    output logic               o_memtoreg,
    output logic               o_regdst,
    output logic               o_regwrite,
    output logic               o_jal,
    output logic               o_alusrca,
    output logic [1:0]         o_alusrcb,
    output logic               o_extop,
    output logic [2:0]         o_aluop,
    output logic [1:0]         o_pcsource,
    output logic               o_illegal,
    output logic [STATE_W-1:0] o_state
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXEC_R  = 4'd6,
        S_ALUWB_R = 4'd7,
        S_EXEC_I  = 4'd8,
        S_ALUWB_I = 4'd9,
        S_BRANCH  = 4'd10,
        S_JUMP    = 4'd11,
        S_JR      = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // A one-bit counter is kept even for MEM_LATENCY == 1 so the logic stays
    // uniform; it then never leaves 0 and every access state is one cycle.
    localparam int              CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LATENCY - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic       w_last;
    logic       w_unused;
    state_t     w_dec_next;
    logic       w_illegal_op;
    logic       w_gate;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_memwrite;
    logic       w_irwrite;
    logic       w_regwrite;
    logic       w_illegal;

    assign w_opcode = i_instruction[31:26];
    assign w_funct  = i_instruction[5:0];
    assign w_unused = ^i_instruction[25:6];
    assign w_last   = (r_cnt == CNT_LAST);

    // Opcode dispatch out of DECODE.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        w_dec_next   = S_FETCH;
        w_illegal_op = 1'b0;
        case (w_opcode)
            OP_LW, OP_SW:     w_dec_next = S_MEMADR;
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_SUB, FN_SLT: w_dec_next = S_EXEC_R;
                    FN_JR:                  w_dec_next = S_JR;
                    default:                w_illegal_op = 1'b1;
                endcase
            end
            OP_ADDI, OP_XORI: w_dec_next = S_EXEC_I;
            OP_BEQ, OP_BNE:   w_dec_next = S_BRANCH;
            OP_J, OP_JAL:     w_dec_next = S_JUMP;
            default:          w_illegal_op = 1'b1;
        endcase
    end

    // State register and memory latency counter. Stall holds both; reset
    // wins over stall.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (i_reset) begin
            r_state <= S_FETCH;
            r_cnt   <= '0;
        end else if (!i_stall) begin
            case (r_state)
                S_FETCH: begin
                    if (w_last) begin
                        r_state <= S_DECODE;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DECODE:  r_state <= w_dec_next;
                S_MEMADR:  r_state <= (w_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
                S_MEMRD: begin
                    if (w_last) begin
                        r_state <= S_MEMWB;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_MEMWR: begin
                    if (w_last) begin
                        r_state <= S_FETCH;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_EXEC_R:  r_state <= S_ALUWB_R;
                S_EXEC_I:  r_state <= S_ALUWB_I;
                S_MEMWB, S_ALUWB_R, S_ALUWB_I, S_BRANCH, S_JUMP, S_JR:
                    r_state <= S_FETCH;
                default: begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Moore output decode. Strobes are produced ungated here and masked by
    // reset/stall below; mux selects are never masked so the datapath sees
    // stable selects while frozen.
    always_comb begin
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_memwrite = 1'b0;
        w_irwrite  = 1'b0;
        w_regwrite = 1'b0;
        w_illegal  = 1'b0;
        o_bne      = 1'b0;
        o_iord     = 1'b0;
        o_memread  = 1'b0;
        o_memtoreg = 1'b0;
        o_regdst   = 1'b0;
        o_jal      = 1'b0;
        o_alusrca  = 1'b0;
        o_alusrcb  = 2'b00;
        o_extop    = 1'b0;
        o_aluop    = 3'b000;
        o_pcsource = 2'b00;
        case (r_state)
            S_FETCH: begin
                o_memread = 1'b1;
                if (w_last) begin
                    // PC + 4 through the ALU while the IR captures the word.
                    w_irwrite = 1'b1;
                    w_pcwrite = 1'b1;
                    o_alusrcb = 2'b01;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut.
                o_alusrcb = 2'b11;
                w_illegal = w_illegal_op;
            end
            S_MEMADR: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                o_iord    = 1'b1;
                o_memread = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                o_memtoreg = 1'b1;
            end
            S_MEMWR: begin
                o_iord     = 1'b1;
                w_memwrite = w_last;
            end
            S_EXEC_R: begin
                o_alusrca = 1'b1;
                case (w_funct)
                    FN_SUB:  o_aluop = 3'b001;
                    FN_SLT:  o_aluop = 3'b011;
                    default: o_aluop = 3'b000;
                endcase
            end
            S_ALUWB_R: begin
                w_regwrite = 1'b1;
                o_regdst   = 1'b1;
            end
            S_EXEC_I: begin
                o_alusrca = 1'b1;
                o_alusrcb = 2'b10;
                if (w_opcode == OP_XORI) begin
                    o_extop = 1'b1;
                    o_aluop = 3'b010;
                end
            end
            S_ALUWB_I: begin
                w_regwrite = 1'b1;
            end
            S_BRANCH: begin
                o_alusrca  = 1'b1;
                o_aluop    = 3'b001;
                w_branch   = 1'b1;
                o_pcsource = 2'b01;
                o_bne      = (w_opcode == OP_BNE);
            end
            S_JUMP: begin
                w_pcwrite  = 1'b1;
                o_pcsource = 2'b10;
                if (w_opcode == OP_JAL) begin
                    // PC already holds PC+4 from FETCH.
                    w_regwrite = 1'b1;
                    o_jal      = 1'b1;
                end
            end
            S_JR: begin
                w_pcwrite  = 1'b1;
                o_pcsource = 2'b11;
            end
            default: ;
        endcase
    end

    assign w_gate     = i_reset | i_stall;
    assign o_pcwrite  = w_pcwrite  & ~w_gate;
    assign o_branch   = w_branch   & ~w_gate;
    assign o_memwrite = w_memwrite & ~w_gate;
    assign o_irwrite  = w_irwrite  & ~w_gate;
    assign o_regwrite = w_regwrite & ~w_gate;
    assign o_illegal  = w_illegal  & ~w_gate;

    assign o_state = STATE_W'(r_state);

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Three controller instances with MEM_LATENCY = 1, 2, 3 (index = L-1).
// Directed per-cycle vectors with hand-written expected outputs, followed by
// cycle-count / strobe-count sequences on the L=3 instance.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

    typedef struct packed {
        logic [3:0] state;
        logic       pcwrite;
        logic       branch;
        logic       bne;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       memtoreg;
        logic       regdst;
        logic       regwrite;
        logic       jal;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       extop;
        logic [2:0] aluop;
        logic [1:0] pcsource;
        logic       illegal;
    } out_t;

    typedef struct {
        int          d;
        logic        rst;
        logic        stl;
        logic [31:0] ins;
        out_t        exp;
    } vec_t;

    localparam logic [31:0] I_ADD  = 32'h0022_1820;
    localparam logic [31:0] I_SUB  = 32'h0022_1822;
    localparam logic [31:0] I_SLT  = 32'h0022_182A;
    localparam logic [31:0] I_ADDU = 32'h0022_1821;  // unsupported funct
    localparam logic [31:0] I_JR   = 32'h0020_0008;
    localparam logic [31:0] I_ADDI = 32'h2022_0005;
    localparam logic [31:0] I_XORI = 32'h3822_0005;
    localparam logic [31:0] I_BEQ  = 32'h1022_0004;
    localparam logic [31:0] I_BNE  = 32'h1422_0004;
    localparam logic [31:0] I_J    = 32'h0800_0010;
    localparam logic [31:0] I_JAL  = 32'h0C00_0010;
    localparam logic [31:0] I_LW   = 32'h8C25_0008;
    localparam logic [31:0] I_SW   = 32'hAC25_0008;
    localparam logic [31:0] I_ILL  = 32'hFC00_0000;  // opcode 0x3F

    logic        clk;
    logic [2:0]  rst_v;
    logic [2:0]  stall_v;
    logic [31:0] instr_v [3];
    out_t        obs [3];

    int checks;
    int failures;

    vec_t vecs[$];

    out_t FW, FL, DE, DI, MA, MR, MB, WW, WL, XA, XS, XT, RW, IA, IX, IW;
    out_t BQ, BN, JP, JL, JRS;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    for (genvar g = 0; g < 3; g++) begin : g_dut
        logic [3:0] st;
        logic       pcw, br, bn, iod, mrd, mwr, irw, m2r, rdst, rw, jl, sa, ext, ill;
        logic [1:0] sb, psrc;
        logic [2:0] aop;

        multicycle_controller #(.MEM_LATENCY(g + 1), .STATE_W(4)) u_dut (
            .i_clk         (clk),
            .i_reset       (rst_v[g]),
            .i_instruction (instr_v[g]),
            .i_stall       (stall_v[g]),
            .o_pcwrite     (pcw),
            .o_branch      (br),
            .o_bne         (bn),
            .o_iord        (iod),
            .o_memread     (mrd),
            .o_memwrite    (mwr),
            .o_irwrite     (irw),
            .o_memtoreg    (m2r),
            .o_regdst      (rdst),
            .o_regwrite    (rw),
            .o_jal         (jl),
            .o_alusrca     (sa),
            .o_alusrcb     (sb),
            .o_extop       (ext),
            .o_aluop       (aop),
            .o_pcsource    (psrc),
            .o_illegal     (ill),
            .o_state       (st)
        );

        assign obs[g] = {st, pcw, br, bn, iod, mrd, mwr, irw, m2r, rdst, rw, jl,
                         sa, sb, ext, aop, psrc, ill};
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    // Expected view of a state while reset or stall masks the write strobes.
    function automatic out_t off(input out_t x);
        out_t y;
        y          = x;
        y.pcwrite  = 1'b0;
        y.branch   = 1'b0;
        y.memwrite = 1'b0;
        y.irwrite  = 1'b0;
        y.regwrite = 1'b0;
        y.illegal  = 1'b0;
        return y;
    endfunction

    task automatic add(input int d, input logic rst, input logic stl,
                       input logic [31:0] ins, input out_t e);
        vec_t v;
        v.d = d; v.rst = rst; v.stl = stl; v.ins = ins; v.exp = e;
        vecs.push_back(v);
    endtask

    // Run one instruction on the L=3 instance, starting at a negedge where it
    // sits in the first FETCH cycle; stop at the negedge of the next FETCH.
    task automatic measure(input logic [31:0] ins, output int cyc, output int mr,
                           output int mw, output int irw, output int rw, output int done);
        int left;
        instr_v[2] = ins;
        cyc = 0; mr = 0; mw = 0; irw = 0; rw = 0; done = 0; left = 0;
        for (int k = 0; k < 40; k++) begin
            if (obs[2].state != 4'd0) begin
                left = 1;
            end else if (left != 0) begin
                done = 1;
                break;
            end
            cyc++;
            mr  += int'(obs[2].memread);
            mw  += int'(obs[2].memwrite);
            irw += int'(obs[2].irwrite);
            rw  += int'(obs[2].regwrite);
            @(negedge clk);
        end
    endtask

    initial begin
        int cyc, mr, mw, irw, rw, done;

        checks   = 0;
        failures = 0;
        rst_v    = 3'b111;
        stall_v  = 3'b000;
        for (int i = 0; i < 3; i++) instr_v[i] = 32'h0;

        FW  = '{state: 4'd0, memread: 1'b1, default: '0};
        FL  = '{state: 4'd0, memread: 1'b1, irwrite: 1'b1, pcwrite: 1'b1, alusrcb: 2'b01, default: '0};
        DE  = '{state: 4'd1, alusrcb: 2'b11, default: '0};
        DI  = '{state: 4'd1, alusrcb: 2'b11, illegal: 1'b1, default: '0};
        MA  = '{state: 4'd2, alusrca: 1'b1, alusrcb: 2'b10, default: '0};
        MR  = '{state: 4'd3, iord: 1'b1, memread: 1'b1, default: '0};
        MB  = '{state: 4'd4, regwrite: 1'b1, memtoreg: 1'b1, default: '0};
        WW  = '{state: 4'd5, iord: 1'b1, default: '0};
        WL  = '{state: 4'd5, iord: 1'b1, memwrite: 1'b1, default: '0};
        XA  = '{state: 4'd6, alusrca: 1'b1, default: '0};
        XS  = '{state: 4'd6, alusrca: 1'b1, aluop: 3'b001, default: '0};
        XT  = '{state: 4'd6, alusrca: 1'b1, aluop: 3'b011, default: '0};
        RW  = '{state: 4'd7, regwrite: 1'b1, regdst: 1'b1, default: '0};
        IA  = '{state: 4'd8, alusrca: 1'b1, alusrcb: 2'b10, default: '0};
        IX  = '{state: 4'd8, alusrca: 1'b1, alusrcb: 2'b10, extop: 1'b1, aluop: 3'b010, default: '0};
        IW  = '{state: 4'd9, regwrite: 1'b1, default: '0};
        BQ  = '{state: 4'd10, alusrca: 1'b1, aluop: 3'b001, branch: 1'b1, pcsource: 2'b01, default: '0};
        BN  = '{state: 4'd10, alusrca: 1'b1, aluop: 3'b001, branch: 1'b1, bne: 1'b1, pcsource: 2'b01, default: '0};
        JP  = '{state: 4'd11, pcwrite: 1'b1, pcsource: 2'b10, default: '0};
        JL  = '{state: 4'd11, pcwrite: 1'b1, pcsource: 2'b10, regwrite: 1'b1, jal: 1'b1, default: '0};
        JRS = '{state: 4'd12, pcwrite: 1'b1, pcsource: 2'b11, default: '0};

        // ---- L = 1: every instruction class ----
        add(0, 1, 0, I_ADD, off(FL));
        add(0, 0, 0, I_ADD, FL);   add(0, 0, 0, I_ADD, DE);   add(0, 0, 0, I_ADD, XA);  add(0, 0, 0, I_ADD, RW);
        add(0, 0, 0, I_SUB, FL);   add(0, 0, 0, I_SUB, DE);   add(0, 0, 0, I_SUB, XS);  add(0, 0, 0, I_SUB, RW);
        add(0, 0, 0, I_SLT, FL);   add(0, 0, 0, I_SLT, DE);   add(0, 0, 0, I_SLT, XT);  add(0, 0, 0, I_SLT, RW);
        add(0, 0, 0, I_ADDI, FL);  add(0, 0, 0, I_ADDI, DE);  add(0, 0, 0, I_ADDI, IA); add(0, 0, 0, I_ADDI, IW);
        add(0, 0, 0, I_XORI, FL);  add(0, 0, 0, I_XORI, DE);  add(0, 0, 0, I_XORI, IX); add(0, 0, 0, I_XORI, IW);
        add(0, 0, 0, I_BEQ, FL);   add(0, 0, 0, I_BEQ, DE);   add(0, 0, 0, I_BEQ, BQ);
        add(0, 0, 0, I_BNE, FL);   add(0, 0, 0, I_BNE, DE);   add(0, 0, 0, I_BNE, BN);
        add(0, 0, 0, I_J, FL);     add(0, 0, 0, I_J, DE);     add(0, 0, 0, I_J, JP);
        add(0, 0, 0, I_JAL, FL);   add(0, 0, 0, I_JAL, DE);   add(0, 0, 0, I_JAL, JL);
        add(0, 0, 0, I_JR, FL);    add(0, 0, 0, I_JR, DE);    add(0, 0, 0, I_JR, JRS);
        add(0, 0, 0, I_ILL, FL);   add(0, 0, 0, I_ILL, DI);
        add(0, 0, 0, I_ADDU, FL);  add(0, 0, 0, I_ADDU, DI);
        add(0, 0, 0, I_SW, FL);    add(0, 0, 0, I_SW, DE);    add(0, 0, 0, I_SW, MA);   add(0, 0, 0, I_SW, WL);
        add(0, 0, 0, I_LW, FL);    add(0, 0, 0, I_LW, DE);    add(0, 0, 0, I_LW, MA);   add(0, 0, 0, I_LW, MR);
        add(0, 0, 0, I_LW, MB);    add(0, 0, 0, I_LW, FL);

        // ---- L = 2: stall in MEMWR, reset in ALUWB_R, stalls in FETCH/DECODE ----
        add(1, 1, 0, I_SW, off(FW));
        add(1, 0, 0, I_SW, FW);    add(1, 0, 0, I_SW, FL);    add(1, 0, 0, I_SW, DE);
        add(1, 0, 0, I_SW, MA);    add(1, 0, 0, I_SW, WW);
        add(1, 0, 1, I_SW, off(WL)); add(1, 0, 1, I_SW, off(WL));
        add(1, 0, 0, I_SW, WL);
        add(1, 0, 0, I_ADD, FW);   add(1, 0, 0, I_ADD, FL);   add(1, 0, 0, I_ADD, DE);
        add(1, 0, 0, I_ADD, XA);   add(1, 1, 0, I_ADD, off(RW));
        add(1, 0, 0, I_ILL, FW);   add(1, 0, 1, I_ILL, off(FL)); add(1, 0, 0, I_ILL, FL);
        add(1, 0, 1, I_ILL, off(DI)); add(1, 0, 0, I_ILL, DI);
        add(1, 0, 0, I_ADDI, FW);  add(1, 0, 0, I_ADDI, FL);  add(1, 0, 0, I_ADDI, DE);
        add(1, 1, 1, I_ADDI, off(IA));
        add(1, 0, 0, I_ADDI, FW);

        // ---- L = 3: LW walk ----
        add(2, 1, 0, I_LW, off(FW));
        add(2, 0, 0, I_LW, FW);    add(2, 0, 0, I_LW, FW);    add(2, 0, 0, I_LW, FL);
        add(2, 0, 0, I_LW, DE);    add(2, 0, 0, I_LW, MA);
        add(2, 0, 0, I_LW, MR);    add(2, 0, 0, I_LW, MR);    add(2, 0, 0, I_LW, MR);
        add(2, 0, 0, I_LW, MB);    add(2, 0, 0, I_LW, FW);

        // Initial reset of all instances.
        repeat (2) @(posedge clk);

        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            // Idle instances are held in reset so each group starts from FETCH.
            rst_v            = 3'b111;
            stall_v          = 3'b000;
            rst_v[vecs[i].d]   = vecs[i].rst;
            stall_v[vecs[i].d] = vecs[i].stl;
            instr_v[vecs[i].d] = vecs[i].ins;
            @(negedge clk);
            check($sformatf("vec%0d_L%0d", i, vecs[i].d + 1),
                  32'(obs[vecs[i].d]), 32'(vecs[i].exp));
        end

        // ---- L = 3: whole-instruction cycle and strobe counts ----
        @(posedge clk);
        #1;
        rst_v   = 3'b111;
        stall_v = 3'b000;
        @(posedge clk);
        #1;
        rst_v[2] = 1'b0;
        @(negedge clk);

        measure(I_SW, cyc, mr, mw, irw, rw, done);
        check("sw_done", 32'(done), 32'd1);
        check("sw_cycles", 32'(cyc), 32'd8);
        check("sw_memwrite_count", 32'(mw), 32'd1);
        check("sw_memread_count", 32'(mr), 32'd3);

        measure(I_LW, cyc, mr, mw, irw, rw, done);
        check("lw_done", 32'(done), 32'd1);
        check("lw_cycles", 32'(cyc), 32'd9);
        check("lw_memread_count", 32'(mr), 32'd6);
        check("lw_irwrite_count", 32'(irw), 32'd1);
        check("lw_regwrite_count", 32'(rw), 32'd1);

        measure(I_ADD, cyc, mr, mw, irw, rw, done);
        check("add_cycles", 32'(cyc), 32'd6);
        check("add_regwrite_count", 32'(rw), 32'd1);

        measure(I_BEQ, cyc, mr, mw, irw, rw, done);
        check("beq_cycles", 32'(cyc), 32'd5);
        check("beq_regwrite_count", 32'(rw), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
